// File: rtl/avm_arb_pkg.sv
// Shared definitions for the Avalon-MM round-robin arbiter: FSM state
// encodings, default geometry and the requester-ID width helper.
package avm_arb_pkg;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ  = 2;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 256;
    localparam int DEF_MAX_PEND = 8;

    // Bits needed to name one requester; never less than one bit.
    function automatic int req_id_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/avm_tag_fifo.sv
// Synchronous FIFO holding the requester ID of every accepted read, in
// issue order, so downstream responses can be routed back to their owner.
// The caller must not push when full or pop when empty.
module avm_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage write port.
    // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/avm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among NUM_REQ requesters.
// Commands pass through combinationally; a stalled command locks the grant
// until accepted. Read responses are routed back in order via a tag FIFO.
module avm_rr_arbiter
    import avm_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [NUM_REQ-1:0]          req_readdatavalid,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [ADDR_W-1:0]           avm_address,
    output logic                        avm_read,
    output logic                        avm_write,
    output logic [DATA_W-1:0]           avm_writedata,
    input  logic                        avm_waitrequest,
    input  logic                        avm_readdatavalid,
    input  logic [DATA_W-1:0]           avm_readdata,
    output logic [$clog2(MAX_PEND):0]   pend_cnt,
    output logic                        err_sticky
);

    localparam int ID_W = req_id_w(NUM_REQ);

    arb_state_e        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   lock_id;

    logic [NUM_REQ-1:0] cmd_rd, cmd_wr, elig;
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    logic              arb_found;
    logic [ID_W-1:0]   arb_id;
    logic [ID_W-1:0]   grant_id;
    logic              grant_valid;
    logic              accept;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ID_W-1:0]   fifo_head;

    // Per-requester command decode: read wins over a simultaneous write,
    // and reads are only eligible while the tag FIFO has room.
    // NOTE: every combinational output is given a value on every path so no latch is inferred.
    always_comb begin
        cmd_rd = req_read;
        cmd_wr = req_write & ~req_read;
        elig   = cmd_wr | (cmd_rd & {NUM_REQ{~fifo_full}});
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_address[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_writedata[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search: first eligible requester starting at rr_ptr.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!arb_found && elig[idx]) begin
                arb_found = 1'b1;
                arb_id    = ID_W'(idx);
            end
        end
    end

    // Next-state and grant decode; everything is squashed while reset is held.
    always_comb begin
        state_nxt   = state;
        grant_id    = arb_id;
        grant_valid = 1'b0;
        accept      = 1'b0;
        case (state)
            ST_ARB: begin
                if (arb_found) begin
                    grant_valid = 1'b1;
                    if (avm_waitrequest) state_nxt = ST_LOCK;
                    else                 accept    = 1'b1;
                end
            end
            ST_LOCK: begin
                grant_id = lock_id;
                if (cmd_rd[lock_id] || cmd_wr[lock_id]) begin
                    grant_valid = 1'b1;
                    if (!avm_waitrequest) begin
                        accept    = 1'b1;
                        state_nxt = ST_ARB;
                    end
                end else begin
                    // Requester abandoned a stalled command: re-arbitrate.
                    state_nxt = ST_ARB;
                end
            end
        endcase
        if (reset) begin
            grant_valid = 1'b0;
            accept      = 1'b0;
        end
    end

    // Downstream command mux and requester handshakes.
    always_comb begin
        avm_read        = grant_valid & cmd_rd[grant_id];
        avm_write       = grant_valid & cmd_wr[grant_id];
        avm_address     = addr_arr[grant_id];
        avm_writedata   = wdata_arr[grant_id];
        req_waitrequest = '1;
        if (accept) req_waitrequest[grant_id] = 1'b0;
    end

    // Response routing: pop the oldest tag and strobe its owner.
    always_comb begin
        fifo_push = accept & cmd_rd[grant_id] & ~fifo_full;
        fifo_pop  = avm_readdatavalid & ~fifo_empty & ~reset;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_readdatavalid[i] = fifo_pop && (fifo_head == ID_W'(i));
        end
        req_readdata = avm_readdata;
    end

    // FSM state, lock owner, round-robin pointer and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_ARB;
            lock_id    <= '0;
            rr_ptr     <= '0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_ARB) lock_id <= arb_id;
            if (accept) begin
                rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
            end
            if (avm_readdatavalid && fifo_empty) err_sticky <= 1'b1;
        end
    end

    avm_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (grant_id),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pend_cnt)
    );

endmodule
